// File: rtl/result_buffer_unload.sv
// result_buffer_unload
// Captures MMU result rows (all lanes in parallel, one row per cycle) into one
// of NUM_BUF local matrix buffers. Later streams a buffer back out serially in
// row-major order under a valid/ready handshake. Per-buffer dimensions are
// tracked so the controller can query them.

module result_buffer_unload #(
    parameter int VAR_SIZE = 8,
    parameter int MMU_SIZE = 10,
    parameter int NUM_BUF  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [1:0]                   cmd,
    input  logic [1:0]                   buffer,
    input  logic [7:0]                   dim_x_in,
    input  logic [7:0]                   dim_y_in,
    input  logic [VAR_SIZE*MMU_SIZE-1:0] row_in,
    input  logic                         row_valid,
    output logic [VAR_SIZE-1:0]          out_data,
    output logic                         out_valid,
    output logic                         out_last,
    input  logic                         out_ready,
    output logic                         busy,
    output logic [7:0]                   dim_x_out,
    output logic [7:0]                   dim_y_out
);

    localparam int ROW_W  = VAR_SIZE * MMU_SIZE;
    localparam int DEPTH  = NUM_BUF * MMU_SIZE;
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [7:0] MAX_DIM  = 8'(MMU_SIZE);
    localparam logic [7:0] LAST_ROW = 8'(MMU_SIZE - 1);

    localparam logic [1:0] CMD_NONE    = 2'b00;
    localparam logic [1:0] CMD_CAPTURE = 2'b01;
    localparam logic [1:0] CMD_SEND    = 2'b10;
    localparam logic [1:0] CMD_CLEAR   = 2'b11;

    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_CAPTURE = 2'b01;
    localparam logic [1:0] ST_SEND    = 2'b10;
    localparam logic [1:0] ST_CLEAR   = 2'b11;

    logic [1:0]       state;
    logic [1:0]       buf_sel;
    logic [7:0]       row;
    logic [7:0]       col;

    logic [7:0]       dim_x_reg [NUM_BUF];
    logic [7:0]       dim_y_reg [NUM_BUF];

    logic [ROW_W-1:0] mem [DEPTH];

    logic [7:0]        cur_dim_x;
    logic [7:0]        cur_dim_y;
    logic              dims_nonzero;
    logic              cap_dims_ok;
    logic              capture_accept;
    logic              clear_accept;
    logic              row_is_last;
    logic              col_is_last;
    logic              transfer;
    logic [ADDR_W-1:0] addr;
    logic              mem_we;
    logic [ROW_W-1:0]  mem_wdata;
    logic [ROW_W-1:0]  rd_row;

    assign cur_dim_x    = dim_x_reg[buf_sel];
    assign cur_dim_y    = dim_y_reg[buf_sel];
    assign dims_nonzero = (cur_dim_x != 8'd0) && (cur_dim_y != 8'd0);

    // A capture is only meaningful when both dimensions fit in a buffer.
    assign cap_dims_ok = (dim_x_in != 8'd0) && (dim_y_in != 8'd0) &&
                         (dim_x_in <= MAX_DIM) && (dim_y_in <= MAX_DIM);

    assign capture_accept = (state == ST_IDLE) && (cmd == CMD_CAPTURE) && cap_dims_ok;
    assign clear_accept   = (state == ST_IDLE) && (cmd == CMD_CLEAR);

    assign row_is_last = (row == 8'(cur_dim_x - 8'd1));
    assign col_is_last = (col == 8'(cur_dim_y - 8'd1));

    assign busy      = (state != ST_IDLE);
    assign out_valid = (state == ST_SEND) && dims_nonzero;
    assign out_last  = out_valid && row_is_last && col_is_last;
    assign transfer  = out_valid && out_ready;

    // Shared row address for both writes and the serial read; pointers beyond
    // the buffer are clamped so the index never leaves the array.
    always_comb begin
        addr = '0;
        if (row < MAX_DIM) begin
            addr = ADDR_W'(int'(buf_sel) * MMU_SIZE + int'(row));
        end else begin
            addr = ADDR_W'(int'(buf_sel) * MMU_SIZE);
        end
    end

    // Write enable and data: captured rows while loading, zero rows while clearing.
    always_comb begin
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (state == ST_CAPTURE && row_valid) begin
            mem_we    = 1'b1;
            mem_wdata = row_in;
        end else if (state == ST_CLEAR) begin
            mem_we    = 1'b1;
            mem_wdata = '0;
        end
    end

    // Select the current element of the current row for the serial output.
    always_comb begin
        rd_row   = mem[addr];
        out_data = '0;
        if (col < MAX_DIM) begin
            out_data = rd_row[int'(col)*VAR_SIZE +: VAR_SIZE];
        end
    end

    // Buffer storage; contents are deliberately not reset, CLEAR initialises them.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[addr] <= mem_wdata;
        end
    end

    // Per-buffer dimension registers, written only when a command is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_BUF; i++) begin
                dim_x_reg[i] <= 8'd0;
                dim_y_reg[i] <= 8'd0;
            end
        end else if (capture_accept) begin
            dim_x_reg[buffer] <= dim_x_in;
            dim_y_reg[buffer] <= dim_y_in;
        end else if (clear_accept) begin
            dim_x_reg[buffer] <= 8'd0;
            dim_y_reg[buffer] <= 8'd0;
        end
    end

    // Registered dimension query of whichever buffer the controller selects.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dim_x_out <= 8'd0;
            dim_y_out <= 8'd0;
        end else begin
            dim_x_out <= dim_x_reg[buffer];
            dim_y_out <= dim_y_reg[buffer];
        end
    end

    // Control FSM: command acceptance in IDLE, pointer stepping in each mode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            buf_sel <= 2'd0;
            row     <= 8'd0;
            col     <= 8'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    row <= 8'd0;
                    col <= 8'd0;
                    case (cmd)
                        CMD_CAPTURE: begin
                            if (cap_dims_ok) begin
                                buf_sel <= buffer;
                                state   <= ST_CAPTURE;
                            end
                        end
                        CMD_SEND: begin
                            buf_sel <= buffer;
                            state   <= ST_SEND;
                        end
                        CMD_CLEAR: begin
                            buf_sel <= buffer;
                            state   <= ST_CLEAR;
                        end
                        default: state <= ST_IDLE;
                    endcase
                end
                ST_CAPTURE: begin
                    if (row_valid) begin
                        if (row_is_last) begin
                            state <= ST_IDLE;
                            row   <= 8'd0;
                        end else begin
                            row <= row + 8'd1;
                        end
                    end
                end
                ST_SEND: begin
                    if (!dims_nonzero) begin
                        state <= ST_IDLE;
                    end else if (transfer) begin
                        if (out_last) begin
                            state <= ST_IDLE;
                            row   <= 8'd0;
                            col   <= 8'd0;
                        end else if (col_is_last) begin
                            col <= 8'd0;
                            row <= row + 8'd1;
                        end else begin
                            col <= col + 8'd1;
                        end
                    end
                end
                ST_CLEAR: begin
                    if (row == LAST_ROW) begin
                        state <= ST_IDLE;
                        row   <= 8'd0;
                    end else begin
                        row <= row + 8'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_result_buffer_unload.sv
// Testbench for result_buffer_unload: expected beats are queued by the
// stimulus and popped/compared by an independent output monitor.

module tb_result_buffer_unload;

    localparam int VAR_SIZE = 8;
    localparam int MMU_SIZE = 10;
    localparam int NUM_BUF  = 4;

    logic                         clk;
    logic                         rst;
    logic [1:0]                   cmd;
    logic [1:0]                   buffer;
    logic [7:0]                   dim_x_in;
    logic [7:0]                   dim_y_in;
    logic [VAR_SIZE*MMU_SIZE-1:0] row_in;
    logic                         row_valid;
    logic [VAR_SIZE-1:0]          out_data;
    logic                         out_valid;
    logic                         out_last;
    logic                         out_ready;
    logic                         busy;
    logic [7:0]                   dim_x_out;
    logic [7:0]                   dim_y_out;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } beat_t;

    beat_t exp_q[$];

    int tests_run = 0;
    int failures  = 0;
    int valid_seen = 0;

    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'd0;
    logic       prev_last  = 1'b0;

    result_buffer_unload #(
        .VAR_SIZE(VAR_SIZE),
        .MMU_SIZE(MMU_SIZE),
        .NUM_BUF (NUM_BUF)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd      (cmd),
        .buffer   (buffer),
        .dim_x_in (dim_x_in),
        .dim_y_in (dim_y_in),
        .row_in   (row_in),
        .row_valid(row_valid),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_last (out_last),
        .out_ready(out_ready),
        .busy     (busy),
        .dim_x_out(dim_x_out),
        .dim_y_out(dim_y_out)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests_run++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Output monitor: pops the scoreboard on every accepted beat and checks
    // that a stalled beat is held unchanged.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) begin
                valid_seen++;
            end
            if (prev_stall) begin
                tests_run++;
                if (!out_valid || out_data !== prev_data || out_last !== prev_last) begin
                    failures++;
                    $display("[TB] FAIL stall_hold: got v=%0b d=%0d l=%0b, expected v=1 d=%0d l=%0b",
                             out_valid, out_data, out_last, prev_data, prev_last);
                end
            end
            if (out_valid && out_ready) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL beat_unexpected: got d=%0d l=%0b, expected no beat",
                             out_data, out_last);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    if (out_data !== e.data || out_last !== e.last) begin
                        failures++;
                        $display("[TB] FAIL beat: got d=%0d l=%0b, expected d=%0d l=%0b",
                                 $signed(out_data), out_last, $signed(e.data), e.last);
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] c, input logic [1:0] b,
                                 input logic [7:0] dx, input logic [7:0] dy);
        cmd      = c;
        buffer   = b;
        dim_x_in = dx;
        dim_y_in = dy;
        tick();
        cmd = 2'b00;
    endtask

    // Waits for busy to fall, bounded; returns the number of cycles spent busy.
    task automatic waitIdle(input string name, output int cycles);
        cycles = 0;
        while (busy && cycles < 400) begin
            tick();
            cycles++;
        end
        if (busy) begin
            tests_run++;
            failures++;
            $display("[TB] FAIL %s_timeout: got busy=1, expected busy=0", name);
        end
    endtask

    task automatic pushBuf1();
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 2; c++) begin
                beat_t e;
                e.data = 8'(10 * r + c);
                e.last = (r == 2 && c == 1);
                exp_q.push_back(e);
            end
        end
    endtask

    initial begin
        int cyc;
        int vs;
        logic [1:0] gap_pat [4];
        gap_pat = '{2'd1, 2'd0, 2'd1, 2'd1};

        rst       = 1'b1;
        cmd       = 2'b00;
        buffer    = 2'd0;
        dim_x_in  = 8'd0;
        dim_y_in  = 8'd0;
        row_in    = '0;
        row_valid = 1'b0;
        out_ready = 1'b0;
        #12;
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_out_last", out_last, 0);
        checkOutput("reset_dim_x_out", dim_x_out, 0);
        checkOutput("reset_dim_y_out", dim_y_out, 0);
        rst = 1'b0;
        tick();

        // CLEAR buffer 1: busy for MMU_SIZE cycles
        applyStimulus(2'b11, 2'd1, 8'd0, 8'd0);
        waitIdle("clear1", cyc);
        checkOutput("clear_cycles", cyc, MMU_SIZE);

        // CAPTURE buffer 1, 3x2, gapped row_valid 1-0-1-1
        applyStimulus(2'b01, 2'd1, 8'd3, 8'd2);
        begin
            int r;
            r = 0;
            for (int i = 0; i < 4; i++) begin
                row_valid = gap_pat[i][0];
                for (int k = 0; k < MMU_SIZE; k++) begin
                    row_in[k*VAR_SIZE +: VAR_SIZE] = 8'(10 * r + k);
                end
                tick();
                if (gap_pat[i][0]) r++;
                if (i == 2) checkOutput("capture_busy_before_last", busy, 1);
            end
            row_valid = 1'b0;
        end
        checkOutput("capture_busy_after_last", busy, 0);
        buffer = 2'd1;
        tick();
        checkOutput("query_dim_x_buf1", dim_x_out, 3);
        checkOutput("query_dim_y_buf1", dim_y_out, 2);

        // SEND buffer 1 with out_ready held high
        out_ready = 1'b1;
        pushBuf1();
        applyStimulus(2'b10, 2'd1, 8'd0, 8'd0);
        waitIdle("send1", cyc);
        checkOutput("send1_cycles", cyc, 6);
        checkOutput("send1_valid_dropped", out_valid, 0);
        checkOutput("send1_queue_drained", exp_q.size(), 0);

        // SEND buffer 1 with out_ready 1,0,0 repeating
        pushBuf1();
        applyStimulus(2'b10, 2'd1, 8'd0, 8'd0);
        cyc = 0;
        while (busy && cyc < 400) begin
            out_ready = (cyc % 3 == 0);
            tick();
            cyc++;
        end
        checkOutput("send_stall_finished", busy, 0);
        checkOutput("send_stall_queue_drained", exp_q.size(), 0);
        out_ready = 1'b1;

        // CAPTURE buffer 2 with 10x10 of -1 then SEND it
        applyStimulus(2'b01, 2'd2, 8'd10, 8'd10);
        row_in    = '1;
        row_valid = 1'b1;
        for (int i = 0; i < MMU_SIZE; i++) tick();
        row_valid = 1'b0;
        checkOutput("capture10_idle", busy, 0);
        for (int i = 0; i < 100; i++) begin
            beat_t e;
            e.data = 8'hFF;
            e.last = (i == 99);
            exp_q.push_back(e);
        end
        applyStimulus(2'b10, 2'd2, 8'd0, 8'd0);
        waitIdle("send2", cyc);
        checkOutput("send2_cycles", cyc, 100);
        checkOutput("send2_queue_drained", exp_q.size(), 0);

        // Buffer 1 untouched by buffer 2 activity
        pushBuf1();
        applyStimulus(2'b10, 2'd1, 8'd0, 8'd0);
        waitIdle("resend1", cyc);
        checkOutput("resend1_queue_drained", exp_q.size(), 0);

        // SEND on a cleared buffer: busy one cycle, no beats
        applyStimulus(2'b11, 2'd3, 8'd0, 8'd0);
        waitIdle("clear3", cyc);
        vs = valid_seen;
        applyStimulus(2'b10, 2'd3, 8'd0, 8'd0);
        checkOutput("send_empty_busy", busy, 1);
        waitIdle("send_empty", cyc);
        checkOutput("send_empty_cycles", cyc, 1);
        tick();
        checkOutput("send_empty_no_valid", valid_seen - vs, 0);

        // CAPTURE with dim_x_in above MMU_SIZE is ignored
        applyStimulus(2'b01, 2'd0, 8'd11, 8'd2);
        checkOutput("capture_oversize_busy", busy, 0);
        buffer = 2'd0;
        tick();
        tick();
        checkOutput("capture_oversize_dim_x", dim_x_out, 0);

        // Reset mid-stream during SEND of buffer 2
        for (int i = 0; i < 100; i++) begin
            beat_t e;
            e.data = 8'hFF;
            e.last = (i == 99);
            exp_q.push_back(e);
        end
        applyStimulus(2'b10, 2'd2, 8'd0, 8'd0);
        tick();
        tick();
        checkOutput("midstream_valid", out_valid, 1);
        checkOutput("midstream_dim_x", dim_x_out, 10);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_reset_valid", out_valid, 0);
        checkOutput("async_reset_busy", busy, 0);
        checkOutput("async_reset_dim_x", dim_x_out, 0);
        #1;
        rst = 1'b0;
        exp_q.delete();
        tick();
        tick();
        checkOutput("post_reset_idle", busy, 0);
        checkOutput("post_reset_no_valid", out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
